// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 device-side transmitter: the transmit FSM
// state encoding, the 11-bit frame layout and its fixed line levels, and a
// helper that assembles a frame from a data byte.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_GAP  = 2'd3
    } ps2_state_t;

    localparam int   FRAME_BITS = 11;
    localparam logic IDLE_BIT   = 1'b1;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    // Frame is sent LSB first: start, data[0..7], odd parity, stop.
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] data);
        return {STOP_BIT, ~^data, data, START_BIT};
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// ps2_byte_fifo
// Small byte queue holding scan codes waiting to be transmitted.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   push, din   : write din when push=1 and the queue is not full
//   pop, dout   : dout is the current head; pop=1 removes it when non-empty
//   full, empty : occupancy flags
//   count       : number of bytes currently stored
module ps2_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    // Pop is qualified on the registered count, so a byte pushed into an
    // empty queue can never leave in the same cycle it arrives.
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage needs no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_device_tx.sv
// ps2_device_tx
// Device-side PS/2 transmitter: queues scan codes and sends each one as an
// 11-bit frame with a self-generated PS/2 clock.
// Ports:
//   CLOCK_50    : system clock
//   resetn      : asynchronous active-low reset
//   key_action  : one-cycle strobe, scan_code is valid
//   scan_code   : byte to queue
//   ps2_inhibit : host is holding the bus; do not start (or abort) a frame
//   PS2_CLK     : PS/2 clock output, idle high
//   PS2_DAT     : PS/2 data output, idle high
//   busy        : transmitter active, byte queued, or aborted byte pending
//   fifo_count  : bytes queued, not counting the one in flight
//   overflow    : sticky, a strobe arrived while the queue was full
module ps2_device_tx
    import ps2_pkg::*;
#(
    parameter int HALF_PERIOD = 1500,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          CLOCK_50,
    input  logic                          resetn,
    input  logic                          key_action,
    input  logic [7:0]                    scan_code,
    input  logic                          ps2_inhibit,
    output logic                          PS2_CLK,
    output logic                          PS2_DAT,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    // Counter is sized for the longest phase (GAP, two half-periods).
    localparam int             CNT_W     = $clog2(2 * HALF_PERIOD);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(2 * HALF_PERIOD - 1);
    localparam logic [3:0]     LAST_BIT  = 4'(FRAME_BITS - 1);

    ps2_state_t            state, state_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [3:0]            bit_idx, bit_idx_next;
    logic                  retry, retry_next;
    logic [FRAME_BITS-1:0] frame;
    logic                  pop;
    logic [7:0]            head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  abort;

    ps2_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (CLOCK_50),
        .rst_n (resetn),
        .push  (key_action),
        .din   (scan_code),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // The host may only abort up to the parity bit; once the stop bit is on
    // the wire the frame is treated as delivered.
    assign abort = ps2_inhibit && (bit_idx < LAST_BIT);

    // Next-state logic. An aborted frame stays in the frame register and is
    // resent (flagged by retry) before anything else is taken from the queue.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        retry_next   = retry;
        pop          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!ps2_inhibit && (retry || !fifo_empty)) begin
                    pop          = !retry;
                    retry_next   = 1'b0;
                    state_next   = ST_HIGH;
                    cnt_next     = HALF_LOAD;
                    bit_idx_next = '0;
                end
            end
            ST_HIGH: begin
                if (abort) begin
                    state_next   = ST_IDLE;
                    retry_next   = 1'b1;
                    cnt_next     = '0;
                    bit_idx_next = '0;
                end else if (cnt == '0) begin
                    state_next = ST_LOW;
                    cnt_next   = HALF_LOAD;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_LOW: begin
                if (abort) begin
                    state_next   = ST_IDLE;
                    retry_next   = 1'b1;
                    cnt_next     = '0;
                    bit_idx_next = '0;
                end else if (cnt == '0) begin
                    if (bit_idx == LAST_BIT) begin
                        state_next = ST_GAP;
                        cnt_next   = GAP_LOAD;
                    end else begin
                        state_next   = ST_HIGH;
                        cnt_next     = HALF_LOAD;
                        bit_idx_next = bit_idx + 4'd1;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State, phase counter, bit index and retry flag.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            retry   <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            retry   <= retry_next;
        end
    end

    // Frame register loads only on a fresh pop, so a retry reuses it intact.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            frame <= {FRAME_BITS{IDLE_BIT}};
        end else if (pop) begin
            frame <= make_frame(head);
        end
    end

    // Overflow is sticky until reset.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            overflow <= 1'b0;
        end else if (key_action && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    assign PS2_CLK = (state != ST_LOW);
    assign PS2_DAT = (state == ST_HIGH || state == ST_LOW) ? frame[bit_idx] : IDLE_BIT;
    assign busy    = (state != ST_IDLE) || !fifo_empty || retry;

endmodule

// File: tb/tb_ps2_device_tx.sv
// tb_ps2_device_tx
// Self-checking bench for ps2_device_tx with HALF_PERIOD=4, FIFO_DEPTH=4.
// A line monitor decodes every frame seen on PS2_CLK/PS2_DAT into a queue;
// directed sequences and a vector table compare those frames and the status
// outputs against hand-computed values.
module tb_ps2_device_tx;

    localparam int HP    = 4;
    localparam int DEPTH = 4;

    logic       CLOCK_50 = 1'b0;
    logic       resetn;
    logic       key_action;
    logic [7:0] scan_code;
    logic       ps2_inhibit;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic       busy;
    logic [2:0] fifo_count;
    logic       overflow;

    int tests_run = 0;
    int tests_failed = 0;

    ps2_device_tx #(.HALF_PERIOD(HP), .FIFO_DEPTH(DEPTH)) dut (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .key_action  (key_action),
        .scan_code   (scan_code),
        .ps2_inhibit (ps2_inhibit),
        .PS2_CLK     (PS2_CLK),
        .PS2_DAT     (PS2_DAT),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .overflow    (overflow)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Line monitor: collects PS2_DAT at each PS2_CLK fall; a long idle
    // stretch discards a partial (aborted) frame.
    logic [10:0] rx_q[$];
    logic [10:0] shreg;
    int          nbits = 0;
    int          idle_run = 0;
    int          fall_total = 0;
    logic        prev_clk = 1'b1;

    always @(negedge CLOCK_50) begin
        if (!resetn) begin
            nbits    = 0;
            idle_run = 0;
            prev_clk = 1'b1;
        end else begin
            if (prev_clk && !PS2_CLK) begin
                fall_total++;
                shreg[nbits] = PS2_DAT;
                nbits++;
                if (nbits == 11) begin
                    rx_q.push_back(shreg);
                    nbits = 0;
                end
            end
            if (PS2_CLK && PS2_DAT) idle_run++;
            else                    idle_run = 0;
            if (idle_run > HP) nbits = 0;
            prev_clk = PS2_CLK;
        end
    end

    typedef struct {
        logic [7:0]  code;
        logic [10:0] frame;
        logic        parity;
    } vec_t;

    vec_t vecs[6];

    // Reference frame: odd parity from an explicit count of ones.
    function automatic logic [10:0] ref_frame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2 == 0), d, 1'b0};
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] code);
        key_action = 1'b1;
        scan_code  = code;
        tick();
        key_action = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget, input string name);
        int c = 0;
        while (rx_q.size() < n && c < budget) begin
            tick();
            c++;
        end
        checkOutput({name, "_timeout"}, int'(rx_q.size() >= n), 1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int c = 0;
        while (busy && c < budget) begin
            tick();
            c++;
        end
        checkOutput({name, "_idle_timeout"}, int'(busy), 0);
    endtask

    // Wait for the given number of clock falls, then for the next HIGH phase.
    task automatic wait_falls(input int target, input string name);
        int base = fall_total;
        int c = 0;
        while ((fall_total - base < target || !PS2_CLK) && c < 300) begin
            tick();
            c++;
        end
        checkOutput({name, "_fall_timeout"}, int'(c < 300), 1);
    endtask

    task automatic pop_frame(input string name, input logic [10:0] expected);
        logic [10:0] f = 11'h0;
        if (rx_q.size() > 0) f = rx_q.pop_front();
        checkOutput(name, int'(f), int'(expected));
    endtask

    initial begin
        int len;
        int falls;
        int gap;
        int peak;
        int c;
        int base;
        logic pclk;

        vecs[0] = '{8'h1C, 11'h438, 1'b0};
        vecs[1] = '{8'hE0, 11'h5C0, 1'b0};
        vecs[2] = '{8'hF0, 11'h7E0, 1'b1};
        vecs[3] = '{8'h00, 11'h600, 1'b1};
        vecs[4] = '{8'hFF, 11'h7FE, 1'b1};
        vecs[5] = '{8'h01, 11'h402, 1'b0};

        resetn      = 1'b0;
        key_action  = 1'b0;
        scan_code   = 8'h00;
        ps2_inhibit = 1'b0;
        repeat (3) tick();
        checkOutput("reset_clk", int'(PS2_CLK), 1);
        checkOutput("reset_dat", int'(PS2_DAT), 1);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_count", int'(fifo_count), 0);
        checkOutput("reset_overflow", int'(overflow), 0);
        resetn = 1'b1;
        repeat (2) tick();

        // Latency, frame length and gap length for a single 0x1C.
        applyStimulus(8'h1C);
        tick();
        checkOutput("start_latency_dat", int'(PS2_DAT), 0);
        checkOutput("start_latency_clk", int'(PS2_CLK), 1);
        len   = 1;
        falls = 0;
        pclk  = PS2_CLK;
        c     = 0;
        while (c < 200) begin
            tick();
            c++;
            if (!pclk && PS2_CLK && falls == 11) break;
            if (pclk && !PS2_CLK) falls++;
            len++;
            pclk = PS2_CLK;
        end
        checkOutput("frame_length", len, 22 * HP);
        gap = 0;
        while (busy && PS2_CLK && PS2_DAT && gap < 50) begin
            gap++;
            tick();
        end
        checkOutput("gap_length", gap, 2 * HP);
        checkOutput("busy_after_gap", int'(busy), 0);
        pop_frame("frame_1C_bits", 11'h438);

        // Single-byte frames from the vector table.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].code);
            wait_frames(1, 200, $sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d_parity", i),
                        int'(rx_q.size() > 0 ? rx_q[0][9] : 1'bx), int'(vecs[i].parity));
            pop_frame($sformatf("vec%0d_frame", i), vecs[i].frame);
            wait_idle(50, $sformatf("vec%0d", i));
        end

        // Back-to-back strobes: order preserved, queue peaks at two.
        applyStimulus(8'hE0);
        peak = int'(fifo_count);
        applyStimulus(8'hF0);
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
        applyStimulus(8'h1C);
        c = 0;
        while (rx_q.size() < 3 && c < 400) begin
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            tick();
            c++;
        end
        checkOutput("b2b_peak_count", peak, 2);
        pop_frame("b2b_frame0", 11'h5C0);
        pop_frame("b2b_frame1", 11'h7E0);
        pop_frame("b2b_frame2", 11'h438);
        wait_idle(50, "b2b");

        // Inhibit while idle holds the FSM but the queue still accepts.
        ps2_inhibit = 1'b1;
        applyStimulus(8'h1C);
        base = fall_total;
        repeat (20) tick();
        checkOutput("inhibit_idle_no_falls", fall_total - base, 0);
        checkOutput("inhibit_idle_count", int'(fifo_count), 1);
        ps2_inhibit = 1'b0;
        wait_frames(1, 200, "inhibit_idle");
        pop_frame("inhibit_idle_frame", 11'h438);
        wait_idle(50, "inhibit_idle");

        // Abort at bit index 5, then full retransmission.
        applyStimulus(8'h1C);
        tick();
        wait_falls(5, "abort5");
        ps2_inhibit = 1'b1;
        tick();
        checkOutput("abort_clk_idle", int'(PS2_CLK), 1);
        checkOutput("abort_dat_idle", int'(PS2_DAT), 1);
        repeat (10) tick();
        ps2_inhibit = 1'b0;
        wait_frames(1, 200, "retransmit");
        wait_idle(50, "retransmit");
        checkOutput("retransmit_frames", rx_q.size(), 1);
        pop_frame("retransmit_frame", 11'h438);

        // Inhibit during the stop bit is ignored: exactly one frame.
        applyStimulus(8'h1C);
        tick();
        wait_falls(10, "stopinh");
        ps2_inhibit = 1'b1;
        repeat (3) tick();
        ps2_inhibit = 1'b0;
        wait_idle(100, "stopinh");
        repeat (40) tick();
        checkOutput("stopinh_frames", rx_q.size(), 1);
        pop_frame("stopinh_frame", 11'h438);

        // Overflow: one frame in flight, five more strobes, last one dropped.
        applyStimulus(8'h21);
        repeat (2) tick();
        for (int i = 2; i <= 6; i++) applyStimulus(8'(8'h20 + i));
        checkOutput("ovf_count_full", int'(fifo_count), 4);
        checkOutput("ovf_flag", int'(overflow), 1);
        wait_frames(5, 700, "ovf");
        wait_idle(60, "ovf");
        repeat (20) tick();
        checkOutput("ovf_frames_sent", rx_q.size(), 5);
        for (int i = 1; i <= 5; i++)
            pop_frame($sformatf("ovf_frame%0d", i), ref_frame(8'(8'h20 + i)));
        checkOutput("ovf_sticky", int'(overflow), 1);

        // Asynchronous reset at bit index 3 with a byte queued.
        applyStimulus(8'h1C);
        applyStimulus(8'h55);
        wait_falls(3, "rst3");
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("rst_clk", int'(PS2_CLK), 1);
        checkOutput("rst_dat", int'(PS2_DAT), 1);
        checkOutput("rst_count", int'(fifo_count), 0);
        checkOutput("rst_overflow", int'(overflow), 0);
        checkOutput("rst_busy", int'(busy), 0);
        base = fall_total;
        repeat (5) tick();
        resetn = 1'b1;
        repeat (150) tick();
        checkOutput("rst_no_falls", fall_total - base, 0);
        checkOutput("rst_no_frames", rx_q.size(), 0);
        applyStimulus(8'h5A);
        wait_frames(1, 200, "rst_resume");
        pop_frame("rst_resume_frame", ref_frame(8'h5A));
        wait_idle(50, "rst_resume");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
